// File: rtl/gcd_ctrl.sv
// Control FSM for a subtraction-based GCD datapath: IDLE -> LOAD -> CALC -> DONE.
// Optional step-limit abort is enabled by defining GCD_TIMEOUT_EN.
module gcd_ctrl #(
  parameter int ITER_W   = 16,
  parameter int MAX_ITER = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic              x_lt_y,
  input  logic              x_ne_y,
  output logic              x_sel,
  output logic              x_en,
  output logic              y_sel,
  output logic              y_en,
  output logic              output_en,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ITER_W-1:0] iter_cnt
);

  typedef enum logic [1:0] {IDLE, LOAD, CALC, DONE} state_t;

  state_t state;
  logic   at_limit;
  logic   step;

  if (MAX_ITER < 0 || longint'(MAX_ITER) >= (longint'(1) << ITER_W)) begin : g_bad_max
    $error("gcd_ctrl: MAX_ITER must fit in ITER_W bits");
  end

`ifdef GCD_TIMEOUT_EN
  logic timeout_r;
  assign at_limit = (iter_cnt == ITER_W'(MAX_ITER));
  assign err      = (state == DONE) && timeout_r;
`else
  assign at_limit = 1'b0;
  assign err      = 1'b0;
`endif

  // A subtract step happens only while operands differ and the limit is not hit.
  assign step = (state == CALC) && x_ne_y && !at_limit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      iter_cnt <= '0;
`ifdef GCD_TIMEOUT_EN
      timeout_r <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (go) state <= LOAD;
        LOAD: begin
          iter_cnt <= '0;
`ifdef GCD_TIMEOUT_EN
          timeout_r <= 1'b0;
`endif
          state <= CALC;
        end
        CALC: begin
          if (!x_ne_y) begin
            state <= DONE;
          end else if (at_limit) begin
`ifdef GCD_TIMEOUT_EN
            timeout_r <= 1'b1;
`endif
            state <= DONE;
          end else if (iter_cnt != '1) begin
            iter_cnt <= iter_cnt + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Controls are decoded from state and live flags so the datapath reacts in the same cycle.
  always_comb begin
    x_sel     = 1'b0;
    x_en      = 1'b0;
    y_sel     = 1'b0;
    y_en      = 1'b0;
    output_en = 1'b0;
    done      = 1'b0;
    busy      = (state != IDLE);
    case (state)
      LOAD: begin
        x_en = 1'b1;
        y_en = 1'b1;
      end
      CALC: begin
        if (step) begin
          if (x_lt_y) begin
            y_en  = 1'b1;
            y_sel = 1'b1;
          end else begin
            x_en  = 1'b1;
            x_sel = 1'b1;
          end
        end else if (!x_ne_y) begin
          output_en = 1'b1;
        end
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_gcd_ctrl.sv
// Closed-loop bench for gcd_ctrl: a behavioural datapath drives the flags and a
// timeline model derived from plain Euclid subtraction predicts every control cycle.
module tb_gcd_ctrl;
  localparam int ITER_W = 16;
`ifdef GCD_TIMEOUT_EN
  localparam int MAX_IT = 10;
  localparam int CAP    = 10;
`else
  localparam int MAX_IT = 65535;
  localparam int CAP    = 32'h7fff_ffff;
`endif

  logic clk = 1'b0;
  logic rst, go, x_lt_y, x_ne_y;
  logic x_sel, x_en, y_sel, y_en, output_en, busy, done, err;
  logic [ITER_W-1:0] iter_cnt;

  logic [15:0] x_in = '0, y_in = '0;
  logic [15:0] rx = '0, ry = '0, out_data = '0;
  logic [7:0]  ctl_now;

  gcd_ctrl #(.ITER_W(ITER_W), .MAX_ITER(MAX_IT)) dut (
    .clk(clk), .rst(rst), .go(go), .x_lt_y(x_lt_y), .x_ne_y(x_ne_y),
    .x_sel(x_sel), .x_en(x_en), .y_sel(y_sel), .y_en(y_en),
    .output_en(output_en), .busy(busy), .done(done), .err(err),
    .iter_cnt(iter_cnt)
  );

  always #5 clk = ~clk;

  // behavioural datapath
  always @(posedge clk) begin
    if (x_en) rx <= x_sel ? rx - ry : x_in;
    if (y_en) ry <= y_sel ? ry - rx : y_in;
    if (output_en) out_data <= rx;
  end
  assign x_lt_y  = rx < ry;
  assign x_ne_y  = rx != ry;
  assign ctl_now = {x_en, x_sel, y_en, y_sel, output_en, busy, done, err};

  typedef struct {
    logic [7:0] ctl;
    int         it;
    int         out;
    int         k;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int compared = 0, mismatched = 0;
  int last_n = 0, last_out = 0;
  int obs_k = -1, obs_out = -1, both_hi = 0;
  bit chk_idle = 1'b0, saw_done = 1'b0;

  task automatic chk(input string nm, input int act, input int exp_v);
    compared++;
    if (act != exp_v) begin
      mismatched++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp_v, exp_v, $time);
    end
  endtask

  function automatic logic [7:0] mk(input logic xe, xs, ye, ys, oe, b, d, er);
    return {xe, xs, ye, ys, oe, b, d, er};
  endfunction

  task automatic push(input logic [7:0] c, input int it, input int out, input int k);
    exp_t t;
    t.ctl = c; t.it = it; t.out = out; t.k = k;
    q.push_back(t);
  endtask

  function automatic int gcd_mod(input int a, input int b);
    int t;
    while (b != 0) begin t = a % b; a = b; b = t; end
    return a;
  endfunction

  // Expected per-cycle timeline, k = cycles after the edge that samples go.
  task automatic build(input int x, input int y);
    int a = x, b = y, n = 0, k = 2;
    push(mk(0,0,0,0,0,0,0,0), last_n, -1, 0);
    push(mk(1,0,1,0,0,1,0,0), last_n, -1, 1);
    while (a != b && n < CAP) begin
      if (a < b) begin b -= a; push(mk(0,0,1,1,0,1,0,0), n, -1, k); end
      else       begin a -= b; push(mk(1,1,0,0,0,1,0,0), n, -1, k); end
      n++; k++;
    end
    if (a == b) begin
      push(mk(0,0,0,0,1,1,0,0), n, -1, k); k++;
      last_out = a;
      push(mk(0,0,0,0,0,1,1,0), n, a, k);
    end else begin
      push(mk(0,0,0,0,0,1,0,0), n, -1, k); k++;
      push(mk(0,0,0,0,0,1,1,1), n, last_out, k);
    end
    last_n = n;
  endtask

  always @(negedge clk) begin
    if (done) saw_done = 1'b1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk($sformatf("ctl_k%0d", e.k), int'(ctl_now), int'(e.ctl));
      chk($sformatf("iter_k%0d", e.k), int'(iter_cnt), e.it);
      if (e.out >= 0) chk("out_data_at_done", int'(out_data), e.out);
      if (e.k >= 2 && x_en && y_en) both_hi++;
      if (done) begin obs_k = e.k; obs_out = int'(out_data); end
    end else if (chk_idle) begin
      chk("idle_ctl", int'(ctl_now), 0);
      chk("idle_iter", int'(iter_cnt), last_n);
    end
  end

  task automatic start(input int x, input int y);
    @(posedge clk); #1;
    x_in = 16'(x); y_in = 16'(y);
    build(x, y);
    obs_k = -1; obs_out = -1; saw_done = 1'b0;
    go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
  endtask

  task automatic finish_run(input bit noise);
    int cyc = 0;
    while (q.size() > 0 && cyc < 70000) begin
      go = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      if (noise && cyc > 0) begin x_in = 16'($urandom); y_in = 16'($urandom); end
      @(posedge clk); #1;
      cyc++;
    end
    go = 1'b0;
    if (q.size() > 0) begin
      chk("run_budget_left", q.size(), 0);
      q.delete();
    end
  endtask

  task automatic reset_pulse();
    chk_idle = 1'b0;
    q.delete();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    last_n = 0;
    chk_idle = 1'b1;
  endtask

  initial begin
    #950_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int x, y, bz, dn;
    rst = 1'b1; go = 1'b1;
    // reset held with go high: idle outputs throughout
    @(posedge clk); #1;
    chk_idle = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b0; go = 1'b0;

    start(12, 8); finish_run(1'b0);
    chk("t2_latency", obs_k, 5);
    chk("t2_out", obs_out, 4);
    chk("t2_iter", int'(iter_cnt), 2);

    start(7, 7); finish_run(1'b1);
    chk("t3_latency", obs_k, 3);
    chk("t3_out", obs_out, 7);
    chk("t3_iter", int'(iter_cnt), 0);

    both_hi = 0;
    start(1, 65535); finish_run(1'b0);
    chk("t4_both_en", both_hi, 0);
`ifndef GCD_TIMEOUT_EN
    chk("t4_iter", int'(iter_cnt), 65534);
    chk("t4_out", obs_out, 1);
`endif

    // abort mid-CALC after five steps
    start(100, 3);
    repeat (6) begin @(posedge clk); #1; end
    chk("t5_iter_mid", int'(iter_cnt), 5);
    saw_done = 1'b0;
    reset_pulse();
    repeat (3) begin @(posedge clk); #1; end
    chk("t5_no_done", int'(saw_done), 0);
    start(9, 6); finish_run(1'b0);
    chk("t5_out", obs_out, 3);

`ifdef GCD_TIMEOUT_EN
    start(0, 5); finish_run(1'b0);
    chk("t6_latency", obs_k, MAX_IT + 3);
    chk("t6_iter", int'(iter_cnt), MAX_IT);
    chk("t6_out_kept", obs_out, 3);
`else
    // one zero operand never converges without the limit
    @(posedge clk); #1;
    x_in = 16'd0; y_in = 16'd5;
    chk_idle = 1'b0;
    go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    bz = 0; dn = 0;
    repeat (40) begin @(negedge clk); bz += int'(busy); dn += int'(done); end
    chk("t6_busy_cycles", bz, 40);
    chk("t6_done_seen", dn, 0);
    @(posedge clk); #1;
    reset_pulse();
`endif

    repeat (25) begin
      x = $urandom_range(1, 300);
      y = $urandom_range(1, 300);
      start(x, y);
      finish_run(1'($urandom_range(0, 1)));
`ifndef GCD_TIMEOUT_EN
      chk($sformatf("rand_gcd_%0d_%0d", x, y), obs_out, gcd_mod(x, y));
`endif
    end

    repeat (2) begin @(posedge clk); #1; end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
